regfile_dump_reader: RTL

//   Debug/trace master that streams a contiguous range of architectural registers out of the

---
 rtl/regfile_dump_reader.sv | 132 +++++++++++++
 1 files changed

// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: walks a contiguous register range through one
// combinational regfile read port and streams each value out over valid/ready.
// One register per cycle when the sink never stalls.
module regfile_dump_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] first_reg,
    input  logic [ADDR_WIDTH-1:0] last_reg,
    output logic [ADDR_WIDTH-1:0] ctrl_readReg,
    input  logic [DATA_WIDTH-1:0] data_readReg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_reg,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } stateT;

    stateT                 state;
    logic [ADDR_WIDTH-1:0] rdPtr;
    logic [ADDR_WIDTH-1:0] endPtr;
    logic                  lastFlag;
    logic                  handshake;

    // Advance the read pointer, parking it on the final register so it can
    // never wrap past the top of the register file.
    function automatic logic [ADDR_WIDTH-1:0] nextPtr(
        input logic [ADDR_WIDTH-1:0] cur,
        input logic [ADDR_WIDTH-1:0] stop
    );
        return (cur == stop) ? cur : cur + ADDR_WIDTH'(1);
    endfunction

    assign ctrl_readReg = rdPtr;
    assign handshake    = out_valid && out_ready;

    // Dump sequencer: one state register, all outputs registered.
    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            state     <= IDLE;
            rdPtr     <= '0;
            endPtr    <= '0;
            out_data  <= '0;
            out_reg   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            lastFlag  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        rdPtr  <= first_reg;
                        endPtr <= last_reg;
                        busy   <= 1'b1;
                        if (first_reg <= last_reg) begin
                            state <= LOAD;
                        end else begin
                            // Empty range: finish without producing a beat.
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        state     <= DONE;
                        done      <= 1'b1;
                    end else begin
                        out_data  <= data_readReg;
                        out_reg   <= rdPtr;
                        out_valid <= 1'b1;
                        lastFlag  <= (rdPtr == endPtr);
                        rdPtr     <= nextPtr(rdPtr, endPtr);
                        state     <= HOLD;
                    end
                end

                HOLD: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        state     <= DONE;
                        done      <= 1'b1;
                    end else if (handshake) begin
                        if (lastFlag) begin
                            out_valid <= 1'b0;
                            state     <= DONE;
                            done      <= 1'b1;
                        end else begin
                            // Refill the buffer on the accepting edge so beats
                            // run back to back with no bubble.
                            out_data  <= data_readReg;
                            out_reg   <= rdPtr;
                            out_valid <= 1'b1;
                            lastFlag  <= (rdPtr == endPtr);
                            rdPtr     <= nextPtr(rdPtr, endPtr);
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
